puf_response_ctrl: RTL and testbench
====================================

// Module: puf_response_ctrl
// PURPOSE
// - Sequences RO-PUF response collection: steps the challenge index, launches one RO-pair measurement per bit,
//   and shifts each comparator bit into an internal WIDTH-bit shift register.
// - Presents each full response word on a valid/ready port; repeats for NUM_WORDS words per run.
// - Sits between the RO counter/comparator stage and the response transport (UART/host readout).
// PARAMETERS
// - WIDTH      8   bits per response word (>=2)
// - NUM_WORDS  4   words collected per start (>=1)
// - CHAL_W     $clog2(WIDTH*NUM_WORDS)   challenge index width (localparam, derived; not overridable)
// PORTS
// - clk         in   1       system clock, all logic on posedge
// - rst         in   1       synchronous, active-high reset
// - start       in   1       begin a run; sampled only in IDLE
// - busy        out  1       high in every state except IDLE
// - chal        out  CHAL_W  challenge index (RO pair select), stable from LAUNCH through end of that bit's WAIT
// - meas_start  out  1       one-cycle pulse: start one RO-pair measurement
// - meas_done   in   1       measurement complete; meas_bit valid this cycle
// - meas_bit    in   1       comparator result for current chal
// - word        out  WIDTH   collected response word
// - word_valid  out  1       word valid (OUTPUT state)
// - word_ready  in   1       consumer accepts word when word_valid & word_ready
// - done        out  1       one-cycle pulse after the last word is accepted
// BEHAVIOUR
// - Reset: state=IDLE; chal=0; bit_cnt=0; word_cnt=0; shift reg=0; busy=0; meas_start=0; word_valid=0; done=0.
// - All outputs are decoded from registered state/counters; no input-to-output combinational path.
// - Shift rule: on accepted bit, sr <= {sr[WIDTH-2:0], meas_bit}; first bit of a word ends in word[WIDTH-1].
// - FSM (IDLE, LAUNCH, WAIT, OUTPUT, FINISH):
//   - IDLE: start=1 -> LAUNCH; chal, bit_cnt, word_cnt, sr cleared to 0.
//   - LAUNCH: meas_start=1 for exactly this cycle -> WAIT.
//   - WAIT: meas_done=0 -> stay. meas_done=1 -> shift meas_bit in.
//     - bit_cnt==WIDTH-1 -> OUTPUT.
//     - Otherwise bit_cnt++, chal++ -> LAUNCH.
//   - OUTPUT: word_valid=1; word held stable; no measurement launched.
//     - word_ready=1 and word_cnt==NUM_WORDS-1 -> FINISH.
//     - word_ready=1 otherwise -> word_cnt++, chal++, bit_cnt=0 -> LAUNCH.
//   - FINISH: done=1 for one cycle -> IDLE. word keeps its last value until the next start.
// - Latency:
//   - start sampled at edge k -> meas_start high in cycle k+1.
//   - meas_done on the last bit at edge j -> word_valid high in cycle j+1.
//   - Final handshake at edge h -> done high in cycle h+1.
// - Boundaries:
//   - start while busy: ignored.
//   - meas_done outside WAIT, including the LAUNCH cycle: ignored. Earliest accepted meas_done is the cycle after meas_start.
//   - word_ready without word_valid: ignored.
//   - word_valid never drops without a handshake. Backpressure stalls indefinitely with chal frozen.
//   - chal never wraps within a run; the last bit uses chal = WIDTH*NUM_WORDS-1.
//   - rst mid-run: immediate return to reset values; no done pulse; partial word discarded.
// CONFIGURATION
// - PUF_RESPONSE_CTRL_PARITY_EN defined:
//   - Adds output port word_parity (out, 1) = ^word, registered with the word.
//   - Valid only while word_valid=1; 0 at reset.
// - Macro undefined: port absent; all other behaviour identical.
// TESTING (WIDTH=8, NUM_WORDS=2)
// - Reset then start; meas_done 2 cycles after each meas_start with bits 1,0,1,1,0,0,1,0
//   -> chal steps 0..7, 8 meas_start pulses, word=8'hB2 with word_valid; ready=1 -> chal=8, LAUNCH.
// - Second word bits 0,0,0,0,0,0,0,1 -> word=8'h01; handshake -> done pulse 1 cycle later; busy=0, chal last=15.
// - Hold word_ready=0 for 5 cycles in OUTPUT -> word, word_valid and chal stable; no meas_start pulses.
// - start pulses and stray meas_done in LAUNCH/OUTPUT -> run unaffected; same words 8'hB2, 8'h01.
// - rst asserted in WAIT of bit 3 -> next cycle all outputs at reset values, no done; new start -> chal restarts at 0.
// - PARITY_EN build: word 8'hB2 -> word_parity=0; word 8'h01 -> word_parity=1.

Source files
------------

// File: rtl/puf_response_ctrl.sv
// -----------------------------------------------------------------------------
// puf_response_ctrl
//
// Purpose:
//   Sequences RO-PUF response collection. For every response bit it selects an
//   RO pair through the challenge index, fires one measurement, and shifts the
//   comparator result into a WIDTH-bit shift register. Each completed word is
//   offered on a valid/ready port; NUM_WORDS words are collected per start.
//
// Parameters:
//   WIDTH      bits per response word (>= 2)
//   NUM_WORDS  words collected per start (>= 1)
//   CHAL_W     challenge index width, derived from WIDTH*NUM_WORDS
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   start        begin a run (sampled only in IDLE)
//   busy         high in every state except IDLE
//   chal         challenge index / RO pair select
//   meas_start   one-cycle pulse launching one RO-pair measurement
//   meas_done    measurement complete, meas_bit valid this cycle
//   meas_bit     comparator result for the current chal
//   word         collected response word
//   word_valid   word offered to the consumer
//   word_ready   consumer accepts when word_valid & word_ready
//   word_parity  ^word, registered with the word (PUF_RESPONSE_CTRL_PARITY_EN only)
//   done         one-cycle pulse after the last word is accepted
//
// Build option:
//   PUF_RESPONSE_CTRL_PARITY_EN  adds the word_parity output.
//
// States:
//   state  | meaning
//   IDLE   | waiting for start, outputs quiet
//   LAUNCH | meas_start pulse for the current chal
//   WAIT   | waiting for meas_done, shifts meas_bit in
//   OUTPUT | word_valid held until the consumer accepts
//   FINISH | done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module puf_response_ctrl #(
  parameter int  WIDTH     = 8,
  parameter int  NUM_WORDS = 4,
  localparam int CHAL_W    = $clog2(WIDTH * NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [CHAL_W-1:0] chal,
  output logic              meas_start,
  input  logic              meas_done,
  input  logic              meas_bit,
  output logic [WIDTH-1:0]  word,
  output logic              word_valid,
  input  logic              word_ready,
`ifdef PUF_RESPONSE_CTRL_PARITY_EN
  output logic              word_parity,
`endif
  output logic              done
);

  localparam int BC_W = $clog2(WIDTH);
  // A single-word run still needs a one-bit counter to stay a legal vector.
  localparam int WC_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WIDTH - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_OUTPUT = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;

  logic              bit_accept;
  logic              last_bit;
  logic [WIDTH-1:0]  sr_shifted;

  assign bit_accept = (state_q == S_WAIT) && meas_done;
  assign last_bit   = (bit_cnt_q == BIT_LAST);
  assign sr_shifted = {sr_q[WIDTH-2:0], meas_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      chal_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sr_q       <= '0;
    end else begin
      state_q    <= state_d;
      chal_q     <= chal_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sr_q       <= sr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    chal_d     = chal_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sr_d       = sr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LAUNCH;
          chal_d     = '0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          sr_d       = '0;
        end
      end

      S_LAUNCH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (meas_done) begin
          sr_d = sr_shifted;
          if (last_bit) begin
            // chal stays on the last pair of the word; it only advances once
            // the word has been handed off.
            state_d = S_OUTPUT;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            chal_d    = chal_q + CHAL_W'(1);
            state_d   = S_LAUNCH;
          end
        end
      end

      S_OUTPUT: begin
        if (word_ready) begin
          if (word_cnt_q == WORD_LAST) begin
            state_d = S_FINISH;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
            chal_d     = chal_q + CHAL_W'(1);
            bit_cnt_d  = '0;
            state_d    = S_LAUNCH;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef PUF_RESPONSE_CTRL_PARITY_EN
  logic parity_q;

  // Parity is captured on the same edge that completes the word, so it is
  // aligned with word for the whole OUTPUT phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      parity_q <= 1'b0;
    end else if (bit_accept && last_bit) begin
      parity_q <= ^sr_shifted;
    end
  end

  assign word_parity = parity_q;
`endif

  // Every output is decoded from registered state only.
  assign busy       = (state_q != S_IDLE);
  assign meas_start = (state_q == S_LAUNCH);
  assign word_valid = (state_q == S_OUTPUT);
  assign done       = (state_q == S_FINISH);
  assign chal       = chal_q;
  assign word       = sr_q;

endmodule

// File: tb/tb_puf_response_ctrl.sv
// -----------------------------------------------------------------------------
// tb_puf_response_ctrl
//
// Purpose:
//   Directed self-checking bench for puf_response_ctrl with WIDTH=8,
//   NUM_WORDS=2. Inputs are driven and outputs sampled on the falling edge.
//   Define PUF_RESPONSE_CTRL_PARITY_EN to also check word_parity.
// -----------------------------------------------------------------------------
module tb_puf_response_ctrl;

  localparam int WIDTH     = 8;
  localparam int NUM_WORDS = 2;
  localparam int CHAL_W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic [CHAL_W-1:0] chal;
  logic              meas_start;
  logic              meas_done;
  logic              meas_bit;
  logic [WIDTH-1:0]  word;
  logic              word_valid;
  logic              word_ready;
  logic              done;
`ifdef PUF_RESPONSE_CTRL_PARITY_EN
  logic              word_parity;
`endif

  int checks     = 0;
  int errors     = 0;
  int ms_count   = 0;
  int done_count = 0;

  puf_response_ctrl #(
    .WIDTH     (WIDTH),
    .NUM_WORDS (NUM_WORDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .chal       (chal),
    .meas_start (meas_start),
    .meas_done  (meas_done),
    .meas_bit   (meas_bit),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
`ifdef PUF_RESPONSE_CTRL_PARITY_EN
    .word_parity(word_parity),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (meas_start === 1'b1) ms_count++;
    if (done === 1'b1) done_count++;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Serve one measurement: wait for the launch, answer 2 cycles after it.
  task automatic do_bit(input logic b, input int exp_chal, input bit stray);
    int n;
    n = 0;
    while (meas_start !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (meas_start !== 1'b1) begin
      errors++;
      $display("FAIL meas_start_timeout: got meas_start=%b, expected 1 (chal %0d)", meas_start, exp_chal);
      return;
    end
    checks++;
    if (chal !== CHAL_W'(exp_chal)) begin
      errors++;
      $display("FAIL chal_launch: got %0d, expected %0d", chal, exp_chal);
    end
    if (stray) begin
      meas_done = 1'b1;
      meas_bit  = ~b;
    end
    cyc();
    meas_done = 1'b0;
    checks++;
    if (meas_start !== 1'b0 || chal !== CHAL_W'(exp_chal) || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_state: got meas_start=%b chal=%0d busy=%b, expected 0/%0d/1",
               meas_start, chal, busy, exp_chal);
    end
    cyc();
    meas_done = 1'b1;
    meas_bit  = b;
    cyc();
    meas_done = 1'b0;
    meas_bit  = 1'b0;
  endtask

  task automatic collect_word(input logic [7:0] bits, input int base, input bit stray);
    int ms0;
    ms0 = ms_count;
    for (int i = 0; i < 8; i++) do_bit(bits[7-i], base + i, stray);
    checks++;
    if (word_valid !== 1'b1 || word !== bits) begin
      errors++;
      $display("FAIL word_out: got valid=%b word=%h, expected 1/%h", word_valid, word, bits);
    end
    checks++;
    if (ms_count - ms0 != 8) begin
      errors++;
      $display("FAIL meas_start_pulses: got %0d, expected 8", ms_count - ms0);
    end
`ifdef PUF_RESPONSE_CTRL_PARITY_EN
    checks++;
    if (word_parity !== ^bits) begin
      errors++;
      $display("FAIL word_parity: got %b, expected %b", word_parity, ^bits);
    end
`endif
  endtask

  task automatic handshake(input bit last, input int exp_next_chal);
    word_ready = 1'b1;
    cyc();
    word_ready = 1'b0;
    if (!last) begin
      checks++;
      if (word_valid !== 1'b0 || meas_start !== 1'b1 || chal !== CHAL_W'(exp_next_chal)) begin
        errors++;
        $display("FAIL next_word_launch: got valid=%b meas_start=%b chal=%0d, expected 0/1/%0d",
                 word_valid, meas_start, chal, exp_next_chal);
      end
    end else begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || word_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: got done=%b busy=%b valid=%b, expected 1/1/0", done, busy, word_valid);
      end
      cyc();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || chal !== 4'd15) begin
        errors++;
        $display("FAIL after_done: got done=%b busy=%b chal=%0d, expected 0/0/15", done, busy, chal);
      end
    end
  endtask

  task automatic kick_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (meas_start !== 1'b1 || busy !== 1'b1 || chal !== 4'd0) begin
      errors++;
      $display("FAIL start_latency: got meas_start=%b busy=%b chal=%0d, expected 1/1/0", meas_start, busy, chal);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    meas_done = 1'b0;
    meas_bit = 1'b0;
    word_ready = 1'b0;
    repeat (3) cyc();
    checks++;
    if (busy !== 1'b0 || chal !== 4'd0 || meas_start !== 1'b0 || word_valid !== 1'b0 ||
        done !== 1'b0 || word !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got busy=%b chal=%0d ms=%b valid=%b done=%b word=%h, expected all 0",
               busy, chal, meas_start, word_valid, done, word);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0 || meas_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b meas_start=%b, expected 0/0", busy, meas_start);
    end
  endtask

  task automatic test_normal_run();
    int d0;
    d0 = done_count;
    kick_start();
    collect_word(8'hB2, 0, 1'b0);
    handshake(1'b0, 8);
    collect_word(8'h01, 8, 1'b0);
    checks++;
    if (done_count != d0) begin
      errors++;
      $display("FAIL early_done: got %0d done pulses, expected 0", done_count - d0);
    end
    handshake(1'b1, 0);
  endtask

  task automatic test_idle_inputs();
    word_ready = 1'b1;
    meas_done  = 1'b1;
    repeat (4) cyc();
    checks++;
    if (busy !== 1'b0 || word_valid !== 1'b0 || meas_start !== 1'b0 || word !== 8'h01) begin
      errors++;
      $display("FAIL idle_stray_inputs: got busy=%b valid=%b ms=%b word=%h, expected 0/0/0/01",
               busy, word_valid, meas_start, word);
    end
    word_ready = 1'b0;
    meas_done  = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    int ms0;
    kick_start();
    collect_word(8'hB2, 0, 1'b0);
    ms0 = ms_count;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      checks++;
      if (word_valid !== 1'b1 || word !== 8'hB2 || chal !== 4'd7 || meas_start !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d got valid=%b word=%h chal=%0d ms=%b, expected 1/b2/7/0",
                 i, word_valid, word, chal, meas_start);
      end
      cyc();
    end
    start = 1'b0;
    checks++;
    if (ms_count != ms0) begin
      errors++;
      $display("FAIL backpressure_launch: got %0d meas_start pulses, expected 0", ms_count - ms0);
    end
    handshake(1'b0, 8);
    collect_word(8'h01, 8, 1'b0);
    handshake(1'b1, 0);
  endtask

  task automatic test_stray_inputs();
    int d0;
    d0 = done_count;
    kick_start();
    start = 1'b1;
    collect_word(8'hB2, 0, 1'b1);
    meas_done = 1'b1;
    meas_bit  = 1'b1;
    repeat (2) cyc();
    checks++;
    if (word_valid !== 1'b1 || word !== 8'hB2 || meas_start !== 1'b0) begin
      errors++;
      $display("FAIL output_stray: got valid=%b word=%h ms=%b, expected 1/b2/0", word_valid, word, meas_start);
    end
    meas_done = 1'b0;
    meas_bit  = 1'b0;
    handshake(1'b0, 8);
    collect_word(8'h01, 8, 1'b1);
    handshake(1'b1, 0);
    start = 1'b0;
    checks++;
    if (done_count - d0 != 1) begin
      errors++;
      $display("FAIL stray_done_count: got %0d, expected 1", done_count - d0);
    end
    cyc();
  endtask

  task automatic test_reset_midrun();
    int d0;
    kick_start();
    do_bit(1'b1, 0, 1'b0);
    do_bit(1'b0, 1, 1'b0);
    do_bit(1'b1, 2, 1'b0);
    checks++;
    if (meas_start !== 1'b1 || chal !== 4'd3) begin
      errors++;
      $display("FAIL bit3_launch: got ms=%b chal=%0d, expected 1/3", meas_start, chal);
    end
    cyc();
    d0 = done_count;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || chal !== 4'd0 || meas_start !== 1'b0 || word_valid !== 1'b0 ||
        done !== 1'b0 || word !== 8'h00) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b chal=%0d ms=%b valid=%b done=%b word=%h, expected all 0",
               busy, chal, meas_start, word_valid, done, word);
    end
    repeat (4) cyc();
    checks++;
    if (done_count != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d done pulses busy=%b, expected 0/0", done_count - d0, busy);
    end
    kick_start();
    collect_word(8'hB2, 0, 1'b0);
    handshake(1'b0, 8);
    collect_word(8'h01, 8, 1'b0);
    handshake(1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_idle_inputs();
    test_backpressure();
    test_stray_inputs();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
